// File: rtl/reg_select_sequencer.sv
// Register-select sequencer: latches an instruction word and presents its Ra/Rb/Rc
// fields one per handshake to the 4-to-16 register-select decoder.
module reg_select_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic [DATA_W-1:0] ir_data,
    output logic              sel_valid,
    input  logic              sel_ready,
    output logic [SEL_W-1:0]  sel_code,
    output logic [1:0]        sel_field,
    output logic              sel_last,
    output logic              done
);

    localparam int unsigned OP_W       = 5;
    localparam int unsigned OP_LSB     = 27;
    localparam int unsigned RA_LSB     = 23;
    localparam int unsigned RB_LSB     = 19;
    localparam int unsigned RC_LSB     = 15;
    localparam int unsigned OP_ALU_MAX = 12;
    localparam int unsigned OP_TWO_MAX = 19;
    localparam int unsigned NF_W       = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EMIT_A = 3'd1,
        EMIT_B = 3'd2,
        EMIT_C = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] hold;
    logic [NF_W-1:0]   nfields;

    logic [OP_W-1:0]   opcode_in;
    logic [SEL_W-1:0]  ra_in;
    logic [SEL_W-1:0]  rb_hold;
    logic [SEL_W-1:0]  rc_hold;
    logic [NF_W-1:0]   nfields_in;

    // Field extraction and instruction-class decode (number of register fields).
    always_comb begin
        opcode_in  = ir_data[OP_LSB +: OP_W];
        ra_in      = ir_data[RA_LSB +: SEL_W];
        rb_hold    = hold[RB_LSB +: SEL_W];
        rc_hold    = hold[RC_LSB +: SEL_W];
        nfields_in = NF_W'(1);
        if (opcode_in <= OP_W'(OP_ALU_MAX)) begin
            nfields_in = NF_W'(3);
        end else if (opcode_in <= OP_W'(OP_TWO_MAX)) begin
            nfields_in = NF_W'(2);
        end
    end

    // Only the register fields of the held word are consumed after acceptance.
    logic unused_bits;
    assign unused_bits = ^{hold, ir_data};

    // Sequencer FSM with registered handshake and select outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            hold      <= '0;
            nfields   <= '0;
            ir_ready  <= 1'b1;
            sel_valid <= 1'b0;
            sel_code  <= '0;
            sel_field <= 2'd0;
            sel_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ir_valid) begin
                        state     <= EMIT_A;
                        hold      <= ir_data;
                        nfields   <= nfields_in;
                        ir_ready  <= 1'b0;
                        sel_valid <= 1'b1;
                        sel_code  <= ra_in;
                        sel_field <= 2'd0;
                        sel_last  <= (nfields_in == NF_W'(1));
                    end
                end
                EMIT_A: begin
                    if (sel_ready) begin
                        if (nfields != NF_W'(1)) begin
                            state     <= EMIT_B;
                            sel_code  <= rb_hold;
                            sel_field <= 2'd1;
                            sel_last  <= (nfields == NF_W'(2));
                        end else begin
                            state     <= DONE;
                            sel_valid <= 1'b0;
                            sel_code  <= '0;
                            sel_field <= 2'd0;
                            sel_last  <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                EMIT_B: begin
                    if (sel_ready) begin
                        if (nfields == NF_W'(3)) begin
                            state     <= EMIT_C;
                            sel_code  <= rc_hold;
                            sel_field <= 2'd2;
                            sel_last  <= 1'b1;
                        end else begin
                            state     <= DONE;
                            sel_valid <= 1'b0;
                            sel_code  <= '0;
                            sel_field <= 2'd0;
                            sel_last  <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                EMIT_C: begin
                    if (sel_ready) begin
                        state     <= DONE;
                        sel_valid <= 1'b0;
                        sel_code  <= '0;
                        sel_field <= 2'd0;
                        sel_last  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    ir_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    ir_ready  <= 1'b1;
                    sel_valid <= 1'b0;
                    sel_code  <= '0;
                    sel_field <= 2'd0;
                    sel_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Bench for reg_select_sequencer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the expected field emissions.
module tb_reg_select_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic        sel_valid;
    logic        sel_ready;
    logic [3:0]  sel_code;
    logic [1:0]  sel_field;
    logic        sel_last;
    logic        done;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [3:0] code;
        logic [1:0] field;
        logic       last;
    } emit_t;

    emit_t exp_q[$];
    logic  exp_done;

    always #5 clk = ~clk;

    reg_select_sequencer #(.DATA_W(32), .SEL_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir_data   (ir_data),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel_code  (sel_code),
        .sel_field (sel_field),
        .sel_last  (sel_last),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
        logic [31:0] w;
        w = $urandom;
        w[31:27] = 5'(op);
        w[26:23] = 4'(ra);
        w[22:19] = 4'(rb);
        w[18:15] = 4'(rc);
        return w;
    endfunction

    // Accepted word expands into its ordered list of field emissions.
    task automatic model_accept(input logic [31:0] w);
        int op;
        int n;
        emit_t e;
        op = int'(w >> 27);
        n  = (op <= 12) ? 3 : (op <= 19) ? 2 : 1;
        for (int i = 0; i < n; i++) begin
            e.code  = 4'((w >> (23 - 4 * i)) & 32'hF);
            e.field = 2'(i);
            e.last  = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d, input logic r);
        if (exp_done) begin
            exp_done = 1'b0;
        end else if (exp_q.size() > 0) begin
            if (r) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done = 1'b1;
            end
        end else if (v) begin
            model_accept(d);
        end
    endtask

    task automatic compare_outputs();
        emit_t h;
        logic  busy;
        h.code = 4'd0; h.field = 2'd0; h.last = 1'b0;
        if (exp_q.size() > 0) h = exp_q[0];
        busy = (exp_q.size() > 0) || exp_done;
        check("ir_ready",  32'(ir_ready),  32'(!busy));
        check("sel_valid", 32'(sel_valid), 32'(exp_q.size() > 0));
        check("sel_code",  32'(sel_code),  32'(h.code));
        check("sel_field", 32'(sel_field), 32'(h.field));
        check("sel_last",  32'(sel_last),  32'(h.last));
        check("done",      32'(done),      32'(exp_done));
    endtask

    // Called at a falling edge: check, drive, step through one rising edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r);
        compare_outputs();
        ir_valid  = v;
        ir_data   = d;
        sel_ready = r;
        @(posedge clk);
        model_edge(v, d, r);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [31:0] w, input int cycles, input logic noisy);
        step(1'b1, w, 1'b1);
        for (int i = 0; i < cycles; i++) begin
            step(noisy, $urandom, 1'b1);
        end
    endtask

    initial begin
        clr       = 1'b1;
        ir_valid  = 1'b0;
        ir_data   = '0;
        sel_ready = 1'b0;
        exp_done  = 1'b0;
        repeat (2) @(negedge clk);
        compare_outputs();
        clr = 1'b0;
        step(1'b0, '0, 1'b0);

        // Three-field ALU op, two-field op, one-field op; each followed by an idle cycle.
        run_op(32'h0A9A8000, 5, 1'b0);
        run_op(mk(13, 2, 15, 6), 4, 1'b0);
        run_op(mk(20, 9, 1, 1), 3, 1'b0);
        run_op(mk(31, 0, 0, 0), 3, 1'b0);
        run_op(mk(12, 0, 15, 0), 5, 1'b0);
        run_op(mk(19, 7, 0, 3), 4, 1'b0);

        // Back-pressure in the first emit cycle.
        step(1'b1, mk(0, 7, 8, 9), 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        repeat (5) step(1'b0, '0, 1'b1);

        // Instruction requests while busy must be ignored.
        run_op(mk(3, 10, 11, 12), 5, 1'b1);

        // Asynchronous reset in the middle of the second field.
        step(1'b1, mk(2, 4, 6, 8), 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        compare_outputs();
        #2 clr = 1'b1;
        #1;
        check("rst_sel_valid", 32'(sel_valid), 32'd0);
        check("rst_ir_ready",  32'(ir_ready),  32'd1);
        check("rst_sel_code",  32'(sel_code),  32'd0);
        check("rst_sel_field", 32'(sel_field), 32'd0);
        check("rst_sel_last",  32'(sel_last),  32'd0);
        check("rst_done",      32'(done),      32'd0);
        exp_q.delete();
        exp_done = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        repeat (4) step(1'b0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
        end
        compare_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/reg_select_sequencer.md
Name: reg_select_sequencer

Overview:
- Sits directly upstream of the 4-to-16 register-select decoder in the CPU datapath.
- Accepts a 32-bit instruction word from the IR stage over a valid/ready handshake.
- Extracts the Ra, Rb and Rc register fields, then presents them one per cycle as a 4-bit select code to the decoder, in the order the instruction class requires.
- Pulses done when the last field has been consumed, so the control unit can advance.

Parameters:
- DATA_W, 32, instruction word width. Field positions below assume 32.
- SEL_W, 4, register select code width. It feeds the 4-to-16 decoder input.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-high reset.
- ir_valid  input  1  instruction word on ir_data is valid.
- ir_ready  output  1  block can accept a new instruction.
- ir_data  input  DATA_W  instruction word: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- sel_valid  output  1  sel_code is valid for the decoder stage.
- sel_ready  input  1  decoder/register-file stage accepts sel_code this cycle.
- sel_code  output  SEL_W  register index for the 4-to-16 decoder.
- sel_field  output  2  field being presented: 0=Ra, 1=Rb, 2=Rc, 3=unused.
- sel_last  output  1  current field is the final one for this instruction.
- done  output  1  one-cycle pulse after the last field handshake.

Behaviour:
- Reset (clr high, asynchronous):
  - State goes to IDLE; the instruction holding register clears to 0.
  - Outputs: ir_ready=1, sel_valid=0, sel_code=0, sel_field=0, sel_last=0, done=0.
  - Takes effect immediately, mid-sequence included. Any in-flight instruction is discarded and no done is issued for it.
- Instruction classes, decoded from the latched opcode at acceptance:
  - opcode 0..12 (3-register ALU ops): emit Ra, Rb, Rc.
  - opcode 13..19 (2-register ops: ld/st/addi/andi/ori/neg/not): emit Ra, Rb.
  - opcode 20..31 (branch, jump, in/out, mfhi/mflo, nop, halt): emit Ra only.
- States and transitions:
  - IDLE, ir_ready=1: on ir_valid, latch ir_data and the class, then go to EMIT_A.
  - EMIT_A, sel_valid=1, sel_code=Ra, sel_field=0: on sel_ready, go to EMIT_B if the class has Rb, else go to DONE.
  - EMIT_B, sel_code=Rb, sel_field=1: on sel_ready, go to EMIT_C if the class has Rc, else go to DONE.
  - EMIT_C, sel_code=Rc, sel_field=2: on sel_ready, go to DONE.
  - DONE: done=1 for exactly one cycle, sel_valid=0, ir_ready=0. Next state is IDLE.
- Handshake rules:
  - A transfer occurs on a rising edge where valid and ready are both high.
  - While sel_valid=1 and sel_ready=0, sel_code, sel_field and sel_last hold stable.
  - sel_valid never drops without a transfer.
  - ir_ready is high only in IDLE; ir_data is ignored in all other states.
- Latency:
  - The first sel_valid is asserted the cycle after IR acceptance.
  - With sel_ready held high, an N-field instruction gives N consecutive sel_valid cycles, then one done cycle, then ir_ready=1.
  - Total from acceptance to the next acceptance: N+2 cycles.
- sel_last is high in the state that emits the final field of the class.
- Field codes are passed unmodified. Register index 0 (R0) is a legal code with no special treatment.
- All outputs are registered or decoded from registered state only. There is no combinational path from ir_data or sel_ready to any output.

Test Plan:
- Reset: assert clr mid-EMIT_B -> same-cycle sel_valid=0, ir_ready=1, sel_code=0; no done pulse follows.
- 3-field ALU op 0x0A9A8000 (opcode 1, Ra=5, Rb=3, Rc=5), sel_ready=1 -> codes 5,3,5 with sel_field 0,1,2 on consecutive cycles; sel_last only on the third; done the next cycle; ir_ready=1 one cycle later.
- 2-field op with opcode 13, Ra=2, Rb=15 -> codes 2 then 15; sel_last on the second; no Rc cycle; done follows.
- 1-field op with opcode 20, Ra=9 -> single cycle with code 9 and sel_last=1, then done.
- Back-pressure: hold sel_ready=0 for 4 cycles in EMIT_A -> sel_code stays stable and sel_valid stays 1; the sequence resumes when sel_ready=1.
- ir_valid pulses while busy -> ignored (ir_ready=0); the holding register is unchanged and the emitted codes are unaffected.
